// File: rtl/flt2int_pkg.sv
// Shared types and constants for the sequential half-float to int16 converter.
package flt2int_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_LO,
      S_RD_HI,
      S_DECODE,
      S_SHIFT,
      S_FIX,
      S_WR_LO,
      S_WR_HI,
      S_DONE
   } state_t;

   localparam int unsigned EXP_BIAS = 15;
   localparam int unsigned MAN_W    = 10;
   localparam int unsigned EXP_W    = 5;
   localparam logic [15:0] INT_MAX  = 16'h7FFF;
   localparam logic [15:0] INT_MIN  = 16'h8000;

endpackage

// File: rtl/flt_field_decode.sv
// Combinational field decode: sign, zero/saturate classification, shift direction and count.
module flt_field_decode
   import flt2int_pkg::*;
(
   input  logic [15:0]      f,
   output logic             sign,
   output logic             is_zero,
   output logic             is_sat,
   output logic             shl,
   output logic [15:0]      sat_val,
   output logic [MAN_W:0]   mag0,
   output logic [3:0]       n
);

   localparam logic [EXP_W-1:0] E_MIN  = EXP_W'(EXP_BIAS);
   localparam logic [EXP_W-1:0] E_UNIT = EXP_W'(EXP_BIAS + MAN_W);
   localparam logic [EXP_W-1:0] E_SAT  = EXP_W'(EXP_BIAS + 15);
   localparam logic [EXP_W-1:0] E_ALL1 = '1;

   logic [EXP_W-1:0] e;
   logic [MAN_W-1:0] m;

   assign e = f[MAN_W+EXP_W-1:MAN_W];
   assign m = f[MAN_W-1:0];

   always_comb begin
      sign    = f[15];
      is_zero = (e < E_MIN);
      is_sat  = (e >= E_SAT);
      shl     = (e > E_UNIT);
      // Infinity/NaN saturate positive regardless of sign; every other overflow follows the sign.
      sat_val = ((e == E_ALL1) || !f[15]) ? INT_MAX : INT_MIN;
      mag0    = {(e != '0) && (e != E_ALL1), m};
      n       = '0;
      if (!is_zero && !is_sat) begin
         n = shl ? 4'(e - E_UNIT) : 4'(E_UNIT - e);
      end
   end

endmodule

// File: rtl/flt2int_seq.sv
// Sequential float-to-int16 converter: reads two source bytes, shifts one bit per cycle, writes two result bytes.
module flt2int_seq
   import flt2int_pkg::*;
#(
   parameter int unsigned SRC_ADDR = 2,
   parameter int unsigned DST_ADDR = 4,
   parameter int unsigned ADDR_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              done,
   output logic              busy,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rd_data,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_data
);

   state_t             state_q, state_d;
   logic               start_q, start_d;
   logic [15:0]        f_q, f_d;
   logic [15:0]        mag_q, mag_d;
   logic [3:0]         cnt_q, cnt_d;
   logic               sign_q, sign_d;
   logic               shl_q, shl_d;
   logic               spec_q, spec_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
   logic               mem_wr_en_q, mem_wr_en_d;
   logic [7:0]         mem_wr_data_q, mem_wr_data_d;

   logic               dec_sign, dec_zero, dec_sat, dec_shl;
   logic [15:0]        dec_sat_val;
   logic [MAN_W:0]     dec_mag0;
   logic [3:0]         dec_n;

   flt_field_decode u_dec (
      .f       (f_q),
      .sign    (dec_sign),
      .is_zero (dec_zero),
      .is_sat  (dec_sat),
      .shl     (dec_shl),
      .sat_val (dec_sat_val),
      .mag0    (dec_mag0),
      .n       (dec_n)
   );

   always_comb begin
      state_d = state_q;
      start_d = start;
      f_d     = f_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      shl_d   = shl_q;
      spec_d  = spec_q;
      case (state_q)
         S_IDLE:   if (start_q) state_d = S_RD_LO;
         S_RD_LO: begin
            f_d[7:0] = mem_rd_data;
            state_d  = S_RD_HI;
         end
         S_RD_HI: begin
            f_d[15:8] = mem_rd_data;
            state_d   = S_DECODE;
         end
         S_DECODE: begin
            sign_d = dec_sign;
            shl_d  = dec_shl;
            cnt_d  = dec_n;
            spec_d = dec_zero || dec_sat;
            if (dec_zero)     mag_d = '0;
            else if (dec_sat) mag_d = dec_sat_val;
            else              mag_d = 16'(dec_mag0);
            state_d = (dec_n != '0) ? S_SHIFT : S_FIX;
         end
         S_SHIFT: begin
            mag_d = shl_q ? (mag_q << 1) : (mag_q >> 1);
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = S_FIX;
         end
         S_FIX: begin
            if (!spec_q && sign_q) mag_d = -mag_q;
            state_d = S_WR_LO;
         end
         S_WR_LO:  state_d = S_WR_HI;
         S_WR_HI:  state_d = S_DONE;
         S_DONE:   if (!start_q) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase

      // Port outputs are registered from the next state so they line up with the state they belong to.
      busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d        = (state_d == S_DONE);
      mem_addr_d    = '0;
      mem_wr_en_d   = 1'b0;
      mem_wr_data_d = '0;
      case (state_d)
         S_RD_LO: mem_addr_d = ADDR_W'(SRC_ADDR);
         S_RD_HI: mem_addr_d = ADDR_W'(SRC_ADDR + 1);
         S_WR_LO: begin
            mem_addr_d    = ADDR_W'(DST_ADDR);
            mem_wr_en_d   = 1'b1;
            mem_wr_data_d = mag_d[7:0];
         end
         S_WR_HI: begin
            mem_addr_d    = ADDR_W'(DST_ADDR + 1);
            mem_wr_en_d   = 1'b1;
            mem_wr_data_d = mag_d[15:8];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         start_q       <= 1'b0;
         f_q           <= '0;
         mag_q         <= '0;
         cnt_q         <= '0;
         sign_q        <= 1'b0;
         shl_q         <= 1'b0;
         spec_q        <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_en_q   <= 1'b0;
         mem_wr_data_q <= '0;
      end else begin
         state_q       <= state_d;
         start_q       <= start_d;
         f_q           <= f_d;
         mag_q         <= mag_d;
         cnt_q         <= cnt_d;
         sign_q        <= sign_d;
         shl_q         <= shl_d;
         spec_q        <= spec_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_wr_data_q <= mem_wr_data_d;
      end
   end

   assign done        = done_q;
   assign busy        = busy_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wr_en   = mem_wr_en_q;
   assign mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_flt2int_seq.sv
// Directed bench for flt2int_seq with a byte-wide data memory model.
module tb_flt2int_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       done, busy, mem_wr_en;
   logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
   logic [7:0] dm [256];

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   always #5 clk = ~clk;

   flt2int_seq #(.SRC_ADDR(2), .DST_ADDR(4), .ADDR_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .done        (done),
      .busy        (busy),
      .mem_addr    (mem_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_data (mem_wr_data)
   );

   assign mem_rd_data = dm[mem_addr];

   always @(posedge clk) begin
      if (mem_wr_en) dm[mem_addr] <= mem_wr_data;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Start at edge k is the first edge that sees start high; latency counts edges until done is seen.
   task automatic run(input logic [15:0] f, input logic [15:0] exp, input int unsigned exp_lat);
      int unsigned cycles;
      int unsigned wr_cnt;
      dm[2] = f[7:0];
      dm[3] = f[15:8];
      dm[4] = 8'hA5;
      dm[5] = 8'hA5;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      cycles = 0;
      wr_cnt = 0;
      while (cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
         if (mem_wr_en) wr_cnt++;
         if (done) break;
      end
      chk($sformatf("lat_%h", f), cycles, exp_lat);
      chk($sformatf("res_%h", f), {16'h0, dm[5], dm[4]}, {16'h0, exp});
      chk($sformatf("wr_%h", f), wr_cnt, 2);
      chk($sformatf("busy_done_%h", f), {31'h0, busy}, 0);
      chk($sformatf("src_%h", f), {16'h0, dm[3], dm[2]}, {16'h0, f});
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("hold_%h", f), {30'h0, done, busy}, 32'h2);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("idle_%h", f), {30'h0, done, busy}, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) dm[i] = 8'h00;

      // Reset and start high together: reset wins.
      start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outs", {done, busy, mem_wr_en, mem_addr, mem_wr_data}, 0);
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("post_rst", {done, busy, mem_wr_en}, 0);

      run(16'h3C00, 16'h0001, 17);
      run(16'hC500, 16'hFFFB, 15);
      run(16'h4D40, 16'h0015, 13);
      run(16'h3BFF, 16'h0000, 7);
      run(16'h6400, 16'h0400, 7);
      run(16'h7000, 16'h2000, 10);
      run(16'hF000, 16'hE000, 10);
      run(16'h0001, 16'h0000, 7);
      run(16'h7BFF, 16'h7FFF, 7);
      run(16'hF800, 16'h8000, 7);
      run(16'hFBFF, 16'h8000, 7);
      run(16'h7E00, 16'h7FFF, 7);
      run(16'hFC00, 16'h7FFF, 7);

      // Reset pulsed low while shifting: nothing written, done stays low.
      dm[2] = 8'h00;
      dm[3] = 8'h3C;
      dm[4] = 8'hA5;
      dm[5] = 8'hA5;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      chk("mid_busy", {31'h0, busy}, 1);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst", {done, busy, mem_wr_en}, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("mid_done", {31'h0, done}, 0);
      chk("mid_dst", {16'h0, dm[5], dm[4]}, 32'hA5A5);

      run(16'h3C00, 16'h0001, 17);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
